mic1_mem_ctrl: RTL and testbench
================================

Name: mic1_mem_ctrl

Overview:
Initiator side of the MIC-1 two-port main memory interface. It accepts single-cycle rd/wr/fetch microcommands from the microsequencer and drives the memory's word port A (MAR/MDR) and byte port B (PC/MBR). It captures returned data into MDR-read and MBR/MBRU registers with valid pulses, enforces the one-access-in-flight-per-port rule, and range-checks addresses. Runs on posedge clk; the memory samples on negedge, so each access completes in one full cycle.

Parameters:
MEMORY_SIZE, 'h0083, memory depth in 32-bit words; legal word addresses are 0..MEMORY_SIZE-1, legal byte addresses are 0..4*MEMORY_SIZE-1.

Ports:
clk  input  1  system clock, posedge active
rst  input  1  asynchronous reset, active-high
cmd_rd  input  1  word read request: read mem[mar]
cmd_wr  input  1  word write request: mem[mar] <= mdr_wdata
cmd_fetch  input  1  byte fetch request at pc
mar  input  32  word address for port A
mdr_wdata  input  32  write data for port A
pc  input  32  byte address for port B
mem_wen_A  output  1  port A write enable
mem_ren_A  output  1  port A read enable
mem_addr_A  output  32  port A word address
mem_wdata_A  output  32  port A write data
mem_ren_B  output  1  port B read enable
mem_addr_B  output  32  port B byte address
mem_rdata_A  input  32  port A read data
mem_rdata_B  input  8  port B read byte
mdr_rdata  output  32  captured word read data
mdr_valid  output  1  one-cycle pulse: mdr_rdata updated
mbr  output  32  fetched byte, sign-extended
mbru  output  32  fetched byte, zero-extended
mbr_valid  output  1  one-cycle pulse: mbr/mbru updated
busy_A  output  1  port A access in flight
busy_B  output  1  port B access in flight
err_overlap  output  1  sticky: command issued to a busy port, or rd and wr in the same cycle
err_range  output  1  sticky: out-of-range address

Behaviour:
- Reset (async, any time): all outputs 0, both FSMs IDLE, sticky errors cleared. Reset mid-access aborts it: enables drop immediately, no valid pulse is produced, no later capture occurs.
- Two independent FSMs, A and B, each with states IDLE and ACCESS.
- Port A, cycle N: posedge samples cmd_rd or cmd_wr while in IDLE -> registers mem_addr_A=mar, mem_wdata_A=mdr_wdata, and mem_ren_A or mem_wen_A=1. State becomes ACCESS and busy_A=1 during cycle N+1. The memory acts at the negedge of N+1.
- Posedge ending N+1: enables clear and state returns to IDLE. On a read, mdr_rdata <= mem_rdata_A and mdr_valid=1 for cycle N+2 only. A write produces no valid pulse.
- mem_addr_A and mem_wdata_A hold their last values while idle.
- Port B is identical, driven by cmd_fetch: mem_addr_B=pc and mem_ren_B=1 in N+1. The posedge ending N+1 captures mbr={{24{b[7]}},b} and mbru={24'b0,b}, and mbr_valid pulses in N+2.
- mem_addr_B is held until the next accepted fetch, because the memory byte-selects combinationally from mem_addr_B.
- Minimum command spacing per port is 2 cycles. A command sampled while that port is in ACCESS is dropped, err_overlap is set, and the in-flight access is unaffected.
- cmd_rd and cmd_wr together in the same cycle: both dropped, err_overlap set.
- Port A and port B run concurrently without interaction. A same-word write and fetch in the same cycle yields whatever byte the memory returns; no ordering is enforced.
- Range check:
  - mar >= MEMORY_SIZE: err_range set and no enable asserted, but the FSM still spends one ACCESS cycle. A read then returns mdr_rdata=0 with mdr_valid pulsed; a write is discarded.
  - pc >= 4*MEMORY_SIZE: same handling, with mbr=mbru=0 and mbr_valid pulsed.
- Sticky errors clear only on reset.

Test Plan:
- Preload mem[5]=32'hDEADBEEF. cmd_rd with mar=5 at cycle 0 -> mem_ren_A=1 and busy_A=1 in cycle 1; mdr_rdata=32'hDEADBEEF and mdr_valid=1 in cycle 2 only.
- cmd_wr with mar=7, mdr_wdata=32'h12345678 at cycle 0; cmd_rd with mar=7 at cycle 2 -> mdr_rdata=32'h12345678 in cycle 4, err_overlap=0.
- mem[1]=32'h80FF7F01; fetch pc=4,5,6,7 spaced 2 cycles apart:
  - mbr = 32'h00000001, 32'h0000007F, 32'hFFFFFFFF, 32'hFFFFFF80.
  - mbru = 32'h01, 32'h7F, 32'hFF, 32'h80.
- cmd_rd at cycle 0 and again at cycle 1 -> err_overlap=1 from cycle 2; exactly one mdr_valid pulse. A simultaneous rd+wr on a fresh run also sets err_overlap with no enables.
- cmd_rd with mar='h83, then cmd_fetch with pc='h20C -> err_range=1, no mem_ren_A/mem_ren_B, mdr_rdata=0 and mbr=0 with valid pulses.
- Assert rst during cycle 1 of a read -> mem_ren_A and busy_A drop immediately; no mdr_valid in cycle 2; the next cmd_rd after release completes normally.

Source files
------------

// File: rtl/mic1_mem_ctrl.sv
// rtl/mic1_mem_ctrl.sv - MIC-1 memory initiator: word port A (MAR/MDR), byte port B (PC/MBR)
module mic1_mem_ctrl #(
    parameter int unsigned MEMORY_SIZE = 32'h0083
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_rd,
    input  logic        cmd_wr,
    input  logic        cmd_fetch,
    input  logic [31:0] mar,
    input  logic [31:0] mdr_wdata,
    input  logic [31:0] pc,
    output logic        mem_wen_A,
    output logic        mem_ren_A,
    output logic [31:0] mem_addr_A,
    output logic [31:0] mem_wdata_A,
    output logic        mem_ren_B,
    output logic [31:0] mem_addr_B,
    input  logic [31:0] mem_rdata_A,
    input  logic [7:0]  mem_rdata_B,
    output logic [31:0] mdr_rdata,
    output logic        mdr_valid,
    output logic [31:0] mbr,
    output logic [31:0] mbru,
    output logic        mbr_valid,
    output logic        busy_A,
    output logic        busy_B,
    output logic        err_overlap,
    output logic        err_range
);

    typedef enum logic {IDLE, ACCESS} state_t;

    state_t state_a_q, state_b_q;
    logic   rd_a_q;
    logic   inr_a_q, inr_b_q;
    logic   inr_a_d, inr_b_d;

    assign inr_a_d = (mar < 32'(MEMORY_SIZE));
    assign inr_b_d = (pc < 32'(4 * MEMORY_SIZE));

    assign busy_A = (state_a_q == ACCESS);
    assign busy_B = (state_b_q == ACCESS);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_a_q   <= IDLE;
            state_b_q   <= IDLE;
            rd_a_q      <= 1'b0;
            inr_a_q     <= 1'b0;
            inr_b_q     <= 1'b0;
            mem_wen_A   <= 1'b0;
            mem_ren_A   <= 1'b0;
            mem_addr_A  <= 32'h0;
            mem_wdata_A <= 32'h0;
            mem_ren_B   <= 1'b0;
            mem_addr_B  <= 32'h0;
            mdr_rdata   <= 32'h0;
            mdr_valid   <= 1'b0;
            mbr         <= 32'h0;
            mbru        <= 32'h0;
            mbr_valid   <= 1'b0;
            err_overlap <= 1'b0;
            err_range   <= 1'b0;
        end else begin
            mdr_valid <= 1'b0;
            mbr_valid <= 1'b0;

            case (state_a_q)
                IDLE: begin
                    if (cmd_rd && cmd_wr) begin
                        err_overlap <= 1'b1;
                    end else if (cmd_rd || cmd_wr) begin
                        mem_addr_A  <= mar;
                        mem_wdata_A <= mdr_wdata;
                        mem_ren_A   <= cmd_rd && inr_a_d;
                        mem_wen_A   <= cmd_wr && inr_a_d;
                        rd_a_q      <= cmd_rd;
                        inr_a_q     <= inr_a_d;
                        state_a_q   <= ACCESS;
                        if (!inr_a_d) err_range <= 1'b1;
                    end
                end
                ACCESS: begin
                    if (cmd_rd || cmd_wr) err_overlap <= 1'b1;
                    mem_ren_A <= 1'b0;
                    mem_wen_A <= 1'b0;
                    state_a_q <= IDLE;
                    // Out-of-range reads still complete, returning zero.
                    if (rd_a_q) begin
                        mdr_rdata <= inr_a_q ? mem_rdata_A : 32'h0;
                        mdr_valid <= 1'b1;
                    end
                end
                default: state_a_q <= IDLE;
            endcase

            case (state_b_q)
                IDLE: begin
                    if (cmd_fetch) begin
                        mem_addr_B <= pc;
                        mem_ren_B  <= inr_b_d;
                        inr_b_q    <= inr_b_d;
                        state_b_q  <= ACCESS;
                        if (!inr_b_d) err_range <= 1'b1;
                    end
                end
                ACCESS: begin
                    if (cmd_fetch) err_overlap <= 1'b1;
                    mem_ren_B <= 1'b0;
                    state_b_q <= IDLE;
                    mbr_valid <= 1'b1;
                    if (inr_b_q) begin
                        mbr  <= {{24{mem_rdata_B[7]}}, mem_rdata_B};
                        mbru <= {24'h0, mem_rdata_B};
                    end else begin
                        mbr  <= 32'h0;
                        mbru <= 32'h0;
                    end
                end
                default: state_b_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mic1_mem_ctrl.sv
// tb/tb_mic1_mem_ctrl.sv - scoreboard bench for mic1_mem_ctrl with a behavioural two-port memory
module tb_mic1_mem_ctrl;

    localparam int unsigned MSIZE = 32'h0083;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_rd, cmd_wr, cmd_fetch;
    logic [31:0] mar, mdr_wdata, pc;
    logic        mem_wen_A, mem_ren_A, mem_ren_B;
    logic [31:0] mem_addr_A, mem_wdata_A, mem_addr_B;
    logic [31:0] mem_rdata_A;
    logic [7:0]  mem_rdata_B;
    logic [31:0] mdr_rdata, mbr, mbru;
    logic        mdr_valid, mbr_valid, busy_A, busy_B, err_overlap, err_range;

    int checks = 0;
    int errors = 0;

    logic [31:0] mem   [0:MSIZE-1];
    logic [31:0] model [0:MSIZE-1];
    logic [31:0] word_b;
    logic [31:0] qa[$];
    logic [7:0]  qb[$];

    always #5 clk = ~clk;

    mic1_mem_ctrl #(.MEMORY_SIZE(MSIZE)) dut (
        .clk(clk), .rst(rst),
        .cmd_rd(cmd_rd), .cmd_wr(cmd_wr), .cmd_fetch(cmd_fetch),
        .mar(mar), .mdr_wdata(mdr_wdata), .pc(pc),
        .mem_wen_A(mem_wen_A), .mem_ren_A(mem_ren_A),
        .mem_addr_A(mem_addr_A), .mem_wdata_A(mem_wdata_A),
        .mem_ren_B(mem_ren_B), .mem_addr_B(mem_addr_B),
        .mem_rdata_A(mem_rdata_A), .mem_rdata_B(mem_rdata_B),
        .mdr_rdata(mdr_rdata), .mdr_valid(mdr_valid),
        .mbr(mbr), .mbru(mbru), .mbr_valid(mbr_valid),
        .busy_A(busy_A), .busy_B(busy_B),
        .err_overlap(err_overlap), .err_range(err_range)
    );

    // Memory acts on the falling edge; byte lane selected combinationally from mem_addr_B.
    always @(negedge clk) begin
        if (mem_wen_A) mem[mem_addr_A[7:0]] = mem_wdata_A;
        if (mem_ren_A) mem_rdata_A = mem[mem_addr_A[7:0]];
        if (mem_ren_B) word_b = mem[mem_addr_B[9:2]];
    end
    assign mem_rdata_B = 8'(word_b >> {mem_addr_B[1:0], 3'b000});

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endfunction

    always @(negedge clk) begin
        if (!rst) begin
            if (mdr_valid) begin
                if (qa.size() == 0) check("mdr_valid_unexpected", 32'(mdr_valid), 32'h0);
                else check("mdr_rdata", mdr_rdata, qa.pop_front());
            end
            if (mbr_valid) begin
                if (qb.size() == 0) check("mbr_valid_unexpected", 32'(mbr_valid), 32'h0);
                else begin
                    logic [7:0] b;
                    b = qb.pop_front();
                    check("mbr", mbr, 32'($signed(b)));
                    check("mbru", mbru, 32'(b));
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        step();
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && (qa.size() != 0 || qb.size() != 0); i++) step();
        check("drain_a", 32'(qa.size()), 32'h0);
        check("drain_b", 32'(qb.size()), 32'h0);
    endtask

    // Issues one command per port in the same cycle, checks the access cycle, then leaves a gap of one.
    task automatic issue_ab(input bit do_a, input bit rd, input bit wr, input logic [31:0] a,
                            input logic [31:0] d, input bit do_b, input logic [31:0] p);
        bit          a_inr, b_inr;
        logic [31:0] w;
        a_inr = (a < MSIZE);
        b_inr = (p < 4 * MSIZE);
        cmd_rd = do_a & rd;
        cmd_wr = do_a & wr;
        mar = a;
        mdr_wdata = d;
        cmd_fetch = do_b;
        pc = p;
        if (do_a && rd) qa.push_back(a_inr ? model[a[7:0]] : 32'h0);
        if (do_a && wr && a_inr) model[a[7:0]] = d;
        if (do_b) begin
            w = b_inr ? model[p[9:2]] : 32'h0;
            qb.push_back(8'(w >> {p[1:0], 3'b000}));
        end
        step();
        cmd_rd = 1'b0;
        cmd_wr = 1'b0;
        cmd_fetch = 1'b0;
        if (do_a) begin
            check("busy_A", 32'(busy_A), 32'h1);
            check("mem_ren_A", 32'(mem_ren_A), 32'(rd && a_inr));
            check("mem_wen_A", 32'(mem_wen_A), 32'(wr && a_inr));
            check("mem_addr_A", mem_addr_A, a);
            if (wr) check("mem_wdata_A", mem_wdata_A, d);
        end
        if (do_b) begin
            check("busy_B", 32'(busy_B), 32'h1);
            check("mem_ren_B", 32'(mem_ren_B), 32'(b_inr));
            check("mem_addr_B", mem_addr_B, p);
        end
        if ((do_a && !a_inr) || (do_b && !b_inr)) check("err_range_set", 32'(err_range), 32'h1);
        step();
    endtask

    initial begin
        bit any_oor;
        rst = 1'b1;
        cmd_rd = 1'b0; cmd_wr = 1'b0; cmd_fetch = 1'b0;
        mar = 32'h0; mdr_wdata = 32'h0; pc = 32'h0;
        word_b = 32'h0;
        mem_rdata_A = 32'h0;
        for (int i = 0; i < int'(MSIZE); i++) begin
            mem[i] = $urandom;
            model[i] = mem[i];
        end
        mem[5] = 32'hDEADBEEF; model[5] = 32'hDEADBEEF;
        mem[1] = 32'h80FF7F01; model[1] = 32'h80FF7F01;

        step();
        check("reset_ctl", {22'h0, mem_wen_A, mem_ren_A, mem_ren_B, mdr_valid, mbr_valid,
                            busy_A, busy_B, err_overlap, err_range, 1'b0}, 32'h0);
        check("reset_addr_A", mem_addr_A, 32'h0);
        check("reset_mdr", mdr_rdata, 32'h0);
        check("reset_mbr", mbr | mbru | mem_addr_B | mem_wdata_A, 32'h0);
        rst = 1'b0;
        step();

        issue_ab(1, 1, 0, 32'd5, 32'h0, 0, 32'h0);
        drain();

        issue_ab(1, 0, 1, 32'd7, 32'h12345678, 0, 32'h0);
        issue_ab(1, 1, 0, 32'd7, 32'h0, 0, 32'h0);
        drain();
        check("no_overlap_wr_rd", 32'(err_overlap), 32'h0);

        for (int i = 4; i < 8; i++) issue_ab(0, 0, 0, 32'h0, 32'h0, 1, 32'(i));
        drain();

        cmd_rd = 1'b1; mar = 32'd5;
        qa.push_back(model[5]);
        step();
        step();
        cmd_rd = 1'b0;
        check("overlap_set", 32'(err_overlap), 32'h1);
        check("overlap_ren_drop", 32'(mem_ren_A), 32'h0);
        drain();

        do_reset();
        check("overlap_cleared", 32'(err_overlap), 32'h0);
        cmd_rd = 1'b1; cmd_wr = 1'b1; mar = 32'd5;
        step();
        cmd_rd = 1'b0; cmd_wr = 1'b0;
        check("rdwr_overlap", 32'(err_overlap), 32'h1);
        check("rdwr_no_enable", {30'h0, mem_ren_A, mem_wen_A}, 32'h0);
        check("rdwr_not_busy", 32'(busy_A), 32'h0);
        step();
        step();

        do_reset();
        issue_ab(1, 1, 0, 32'h83, 32'h0, 1, 32'h20C);
        drain();
        check("range_err", 32'(err_range), 32'h1);

        do_reset();
        cmd_rd = 1'b1; mar = 32'd5;
        step();
        cmd_rd = 1'b0;
        check("pre_rst_ren", 32'(mem_ren_A), 32'h1);
        check("pre_rst_busy", 32'(busy_A), 32'h1);
        rst = 1'b1;
        #1;
        check("rst_ren_drop", 32'(mem_ren_A), 32'h0);
        check("rst_busy_drop", 32'(busy_A), 32'h0);
        step();
        step();
        rst = 1'b0;
        step();
        step();
        issue_ab(1, 1, 0, 32'd5, 32'h0, 0, 32'h0);
        drain();

        do_reset();
        any_oor = 1'b0;
        for (int n = 0; n < 300; n++) begin
            bit          da, db, isrd;
            logic [31:0] a, p;
            da = ($urandom_range(0, 3) != 0);
            db = ($urandom_range(0, 3) != 0);
            isrd = $urandom_range(0, 1);
            a = $urandom_range(0, 32'h90);
            if (!isrd && a < MSIZE) a = a % 64;
            p = $urandom_range(256, 32'h22F);
            if ((da && a >= MSIZE) || (db && p >= 4 * MSIZE)) any_oor = 1'b1;
            if (da || db) issue_ab(da, isrd, !isrd, a, $urandom, db, p);
            else step();
        end
        drain();
        check("rand_no_overlap", 32'(err_overlap), 32'h0);
        check("rand_err_range", 32'(err_range), 32'(any_oor));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
